// File: rtl/bcd_serial_adder_ctrl.sv
// Packed-BCD adder that reuses one digit add stage, LSD first, one digit per clock.
// Operands are latched on an accepted start; done pulses for one cycle when sum/carry are final.
module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  input  logic                  carry_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   sum_o,
  output logic                  carry_o,
  output logic                  invalid_o
);

  localparam int unsigned DW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [DW-1:0]    sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             inv_q, inv_d;
  logic             busy_q, done_q;

  logic [3:0]       dig_a, dig_b, dig_s;
  logic [4:0]       t;
  logic             c_nxt;

  function automatic logic has_bad_digit(input logic [DW-1:0] v);
    logic r;
    r = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (v[k*4 +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  // Next-state and datapath for the shared digit stage
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    dig_a   = 4'd0;
    dig_b   = 4'd0;
    dig_s   = 4'd0;
    c_nxt   = 1'b0;

    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == CNT_W'(k)) begin
        dig_a = a_q[k*4 +: 4];
        dig_b = b_q[k*4 +: 4];
      end
    end

    t = 5'(dig_a) + 5'(dig_b) + 5'(c_q);
    if (t > 5'd9) begin
      dig_s = 4'(t + 5'd6);
      c_nxt = 1'b1;
    end else begin
      dig_s = t[3:0];
      c_nxt = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = carry_in_i;
          idx_d   = '0;
          sum_d   = '0;
          inv_d   = has_bad_digit(a_i) | has_bad_digit(b_i);
          state_d = ADD;
        end
      end
      ADD: begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          if (idx_q == CNT_W'(k)) sum_d[k*4 +: 4] = dig_s;
        end
        c_d = c_nxt;
        if (idx_q == CNT_W'(DIGITS - 1)) begin
          carry_d = c_nxt;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      busy_q  <= (state_d == ADD);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sum_o     = sum_q;
  assign carry_o   = carry_q;
  assign invalid_o = inv_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl: a 4-digit instance plus a 1-digit instance
// swept exhaustively against a decimal model.
module tb_bcd_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s4, ci4, busy4, done4, c4, inv4;
  logic [15:0] a4, b4, sum4;
  logic        s1, ci1, busy1, done1, c1, inv1;
  logic [3:0]  a1, b1, sum1;

  int total = 0;
  int bad   = 0;

  bcd_serial_adder_ctrl #(.DIGITS(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(s4), .a_i(a4), .b_i(b4), .carry_in_i(ci4),
    .busy_o(busy4), .done_o(done4), .sum_o(sum4), .carry_o(c4), .invalid_o(inv4)
  );

  bcd_serial_adder_ctrl #(.DIGITS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(s1), .a_i(a1), .b_i(b1), .carry_in_i(ci1),
    .busy_o(busy1), .done_o(done1), .sum_o(sum1), .carry_o(c1), .invalid_o(inv1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic [15:0] es, input logic ec, input logic ei);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; ci4 = ci; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    n  = 1;
    chk({tag, "_busy"}, 32'(busy4), 32'd1);
    while (!done4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk({tag, "_sum"}, 32'(sum4), 32'(es));
    chk({tag, "_carry"}, 32'(c4), 32'(ec));
    chk({tag, "_inv"}, 32'(inv4), 32'(ei));
    chk({tag, "_busy_done"}, 32'(busy4), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done4), 32'd0);
    chk({tag, "_hold"}, 32'({c4, sum4}), 32'({ec, es}));
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int n;
    int t;
    logic [3:0] es;
    logic       ec;
    t  = int'(a) + int'(b) + int'(ci);
    ec = (t > 9);
    es = ec ? 4'(t - 10) : 4'(t);
    @(negedge clk);
    a1 = a; b1 = b; ci1 = ci; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    n  = 1;
    while (!done1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d1_%0d_%0d_%0d_lat", a, b, ci), 32'(n), 32'd2);
    chk($sformatf("d1_%0d_%0d_%0d_res", a, b, ci), 32'({c1, sum1}), 32'({ec, es}));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    s1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    #12;
    chk("rst_outs4", 32'({busy4, done4, c4, inv4, sum4}), 32'd0);
    chk("rst_outs1", 32'({busy1, done1, c1, inv1, sum1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run4("basic",    16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run4("wrap",     16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run4("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run4("max",      16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    run4("invalid",  16'h00A3, 16'h0001, 1'b0, 16'h0104, 1'b0, 1'b1);
    run4("inv_clr",  16'h0450, 16'h0550, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Start held high across an operation with operands changed after the latch edge
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h5678; ci4 = 1'b0; s4 = 1'b1;
    @(negedge clk);
    a4 = 16'h1111; b4 = 16'h2222;
    n = 1;
    while (!done4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("held_lat1", 32'(n), 32'd5);
    chk("held_sum1", 32'(sum4), 32'h6912);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done4 && n < 30);
    s4 = 1'b0;
    chk("held_gap", 32'(n), 32'd6);
    chk("held_sum2", 32'(sum4), 32'h3333);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) n++;
    end
    chk("held_no_third", 32'(n), 32'd0);

    // Asynchronous reset in the second ADD cycle
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h5678; ci4 = 1'b1; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({busy4, done4, c4, inv4, sum4}), 32'd0);
    @(negedge clk);
    chk("rst_held", 32'({busy4, done4, c4, inv4, sum4}), 32'd0);
    rst_n = 1'b1;
    run4("post_rst", 16'h0808, 16'h0909, 1'b1, 16'h1718, 1'b0, 1'b0);

    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        run1(4'(x), 4'(y), 1'b0);
        run1(4'(x), 4'(y), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
